// File: rtl/pwm_tick_pkg.sv
// -----------------------------------------------------------------------------
// pwm_tick_pkg
// Shared constants and types for the pwm_tick_gen block.
//   PWM_WIDTH_DEFAULT : default width of counter, period and duty
//   pwm_state_e       : run-state encoding (IDLE, RUN)
// -----------------------------------------------------------------------------
package pwm_tick_pkg;

    localparam int PWM_WIDTH_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_shadow_reg.sv
// -----------------------------------------------------------------------------
// pwm_shadow_reg
// Staging registers for period/duty updates requested while the generator
// runs. A write lands in the shadow copy and raises pending; the owner copies
// the shadow into the active registers on the next period wrap, which clears
// pending. A write on the same edge as a wrap wins: the shadow takes the new
// values and pending stays set for the following wrap.
// The module only exists when PWM_TICK_GEN_SHADOW_EN is defined.
// Ports:
//   clk_in      : clock, rising edge
//   rst         : synchronous active-high reset
//   clr         : drop any pending update (generator not running)
//   wr          : capture period/duty into the shadow registers
//   wrap        : period wrap of the owning counter
//   period      : new period value
//   duty        : new duty value
//   shadow_per  : staged period
//   shadow_duty : staged duty
//   pending     : staged values not yet applied
// -----------------------------------------------------------------------------
`ifdef PWM_TICK_GEN_SHADOW_EN
module pwm_shadow_reg
    import pwm_tick_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic             wrap,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] shadow_per,
    output logic [WIDTH-1:0] shadow_duty,
    output logic             pending
);

    logic [WIDTH-1:0] shadow_per_r;
    logic [WIDTH-1:0] shadow_duty_r;
    logic             pending_r;

    // Shadow value capture; the last write before a wrap wins.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            shadow_per_r  <= '0;
            shadow_duty_r <= '0;
        end else if (wr) begin
            shadow_per_r  <= period;
            shadow_duty_r <= duty;
        end else begin
            shadow_per_r  <= shadow_per_r;
            shadow_duty_r <= shadow_duty_r;
        end
    end

    // Pending flag: a write outranks a coincident wrap so new values wait.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pending_r <= 1'b0;
        end else if (clr) begin
            pending_r <= 1'b0;
        end else if (wr) begin
            pending_r <= 1'b1;
        end else if (wrap) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

    assign shadow_per  = shadow_per_r;
    assign shadow_duty = shadow_duty_r;
    assign pending     = pending_r;

endmodule
`endif

// File: rtl/pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// pwm_tick_gen
// Tick-driven PWM generator with an IDLE/RUN state machine. While running,
// the counter advances on each prescaler tick and wraps at per_act-1; the
// output is high while the counter is below duty_act.
// Optional feature macro: PWM_TICK_GEN_SHADOW_EN
//   defined   : a load while running is staged in pwm_shadow_reg and applied
//               on the next period wrap
//   undefined : a load while running updates period/duty immediately
// Ports:
//   clk_in      : clock, rising edge
//   rst         : synchronous active-high reset
//   en          : run enable, low returns to IDLE
//   tick        : one-cycle count strobe
//   period      : PWM period in ticks (captured on start / load)
//   duty        : high time in ticks (captured on start / load)
//   load        : request to capture period/duty while running
//   pwm_out     : registered PWM waveform
//   period_done : one-cycle pulse on each period wrap
//   busy        : high while in RUN
// -----------------------------------------------------------------------------
module pwm_tick_gen
    import pwm_tick_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    input  logic             load,
    output logic             pwm_out,
    output logic             period_done,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    pwm_state_e       state_r;
    pwm_state_e       next_state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] per_act_r;
    logic [WIDTH-1:0] duty_act_r;
    logic             pwm_out_r;
    logic             period_done_r;
    logic             busy_r;

    logic             run_s;
    logic             start_s;
    logic             count_s;
    logic             wrap_s;
    logic             load_run_s;
    logic             upd_s;
    logic [WIDTH-1:0] upd_per_s;
    logic [WIDTH-1:0] upd_duty_s;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: en alone selects between IDLE and RUN.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (!en) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // run_s is true only on edges where RUN is held, so the edge that leaves
    // RUN already drives the IDLE values (cnt, pwm_out, period_done at 0).
    // The >= compare makes a shrunken period wrap on the next tick instead of
    // counting up through 2^WIDTH.
    assign run_s      = (state_r == RUN) && en;
    assign start_s    = (state_r == IDLE) && en;
    assign count_s    = run_s && tick && (per_act_r != '0);
    assign wrap_s     = count_s && (cnt_r >= (per_act_r - ONE_W));
    assign load_run_s = run_s && load;

`ifdef PWM_TICK_GEN_SHADOW_EN
    logic [WIDTH-1:0] shadow_per_s;
    logic [WIDTH-1:0] shadow_duty_s;
    logic             pending_s;

    pwm_shadow_reg #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk_in      (clk_in),
        .rst         (rst),
        .clr         (!run_s),
        .wr          (load_run_s),
        .wrap        (wrap_s),
        .period      (period),
        .duty        (duty),
        .shadow_per  (shadow_per_s),
        .shadow_duty (shadow_duty_s),
        .pending     (pending_s)
    );

    // Staged values apply on the wrap; a coincident load only refills the
    // shadow, so this wrap still sees the previous contents.
    assign upd_s      = wrap_s && pending_s;
    assign upd_per_s  = shadow_per_s;
    assign upd_duty_s = shadow_duty_s;
`else
    // Load while running takes effect at once; cnt is left alone.
    assign upd_s      = load_run_s;
    assign upd_per_s  = period;
    assign upd_duty_s = duty;
`endif

    // Active period/duty: captured on start, then updated by load/wrap.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            per_act_r  <= '0;
            duty_act_r <= '0;
        end else if (start_s) begin
            per_act_r  <= period;
            duty_act_r <= duty;
        end else if (upd_s) begin
            per_act_r  <= upd_per_s;
            duty_act_r <= upd_duty_s;
        end else begin
            per_act_r  <= per_act_r;
            duty_act_r <= duty_act_r;
        end
    end

    // Tick counter.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (!run_s) begin
            cnt_r <= '0;
        end else if (wrap_s) begin
            cnt_r <= '0;
        end else if (count_s) begin
            cnt_r <= cnt_r + ONE_W;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Registered outputs; pwm_out trails cnt by one cycle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pwm_out_r     <= 1'b0;
            period_done_r <= 1'b0;
            busy_r        <= 1'b0;
        end else if (!run_s) begin
            pwm_out_r     <= 1'b0;
            period_done_r <= 1'b0;
            busy_r        <= (next_state_s == RUN);
        end else begin
            pwm_out_r     <= (per_act_r != '0) && (cnt_r < duty_act_r);
            period_done_r <= wrap_s;
            busy_r        <= (next_state_s == RUN);
        end
    end

    assign pwm_out     = pwm_out_r;
    assign period_done = period_done_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_pwm_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_tick_gen
// Directed bench for pwm_tick_gen. The driver applies one input vector per
// cycle and queues the hand-computed outputs expected after the next rising
// edge; an independent monitor pops and compares them every cycle.
// -----------------------------------------------------------------------------
module tb_pwm_tick_gen;

    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         en;
    logic         tick;
    logic [W-1:0] period;
    logic [W-1:0] duty;
    logic         load;
    logic         pwm_out;
    logic         period_done;
    logic         busy;

    typedef struct packed {
        logic pwm;
        logic pd;
        logic bsy;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_step = 0;

    pwm_tick_gen #(.WIDTH(W)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .tick        (tick),
        .period      (period),
        .duty        (duty),
        .load        (load),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input logic r, input logic e, input logic t, input logic l,
                        input logic [W-1:0] p, input logic [W-1:0] d,
                        input logic xp, input logic xd, input logic xb, input string nm);
        exp_t x;
        @(negedge clk_in);
        rst    = r;
        en     = e;
        tick   = t;
        load   = l;
        period = p;
        duty   = d;
        x.pwm  = xp;
        x.pd   = xd;
        x.bsy  = xb;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Shorthand for a running tick step with no load.
    task automatic run_tick(input logic xp, input logic xd, input string nm);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0, xp, xd, 1'b1, nm);
    endtask

    task automatic stop(input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    // Monitor: compare the DUT outputs after every rising edge.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk_in);
            #1;
            if (exp_q.size() != 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_step++;
                n_cmp++;
                if (pwm_out !== x.pwm) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d): pwm_out got %b want %b", nm, n_step, pwm_out, x.pwm);
                end
                n_cmp++;
                if (period_done !== x.pd) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d): period_done got %b want %b", nm, n_step, period_done, x.pd);
                end
                n_cmp++;
                if (busy !== x.bsy) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d): busy got %b want %b", nm, n_step, busy, x.bsy);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; en = 1'b0; tick = 1'b0; load = 1'b0; period = 16'd0; duty = 16'd0;

        // Reset state.
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, "reset");
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'd9, 16'd9, 1'b0, 1'b0, 1'b0, "reset_prio");
        stop("idle");

        // period=4 duty=1: pwm 1,0,0,0 and one period_done per 4 ticks.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 16'd1, 1'b0, 1'b0, 1'b1, "a_start");
        for (int k = 0; k < 2; k++) begin
            run_tick(1'b1, 1'b0, "a_c1");
            run_tick(1'b0, 1'b0, "a_c2");
            run_tick(1'b0, 1'b0, "a_c3");
            run_tick(1'b0, 1'b1, "a_wrap");
        end
        run_tick(1'b1, 1'b0, "a_c1b");
        stop("a_stop");
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, "idle_ignore");

        // period=5 duty=0: constant low, wrap every 5 ticks, tick=0 holds.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd5, 16'd0, 1'b0, 1'b0, 1'b1, "b_start");
        run_tick(1'b0, 1'b0, "b_c1");
        run_tick(1'b0, 1'b0, "b_c2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, "b_hold");
        run_tick(1'b0, 1'b0, "b_c3");
        run_tick(1'b0, 1'b0, "b_c4");
        run_tick(1'b0, 1'b1, "b_wrap");
        run_tick(1'b0, 1'b0, "b_c1b");
        stop("b_stop");

        // period=5 duty=7: constant high, wrap every 5 ticks.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd5, 16'd7, 1'b0, 1'b0, 1'b1, "b7_start");
        run_tick(1'b1, 1'b0, "b7_c1");
        run_tick(1'b1, 1'b0, "b7_c2");
        run_tick(1'b1, 1'b0, "b7_c3");
        run_tick(1'b1, 1'b0, "b7_c4");
        run_tick(1'b1, 1'b1, "b7_wrap");
        run_tick(1'b1, 1'b0, "b7_c1b");
        stop("b7_stop");

        // period=0: low output, no wrap, still busy.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 16'd3, 1'b0, 1'b0, 1'b1, "c_start");
        for (int k = 0; k < 4; k++) begin
            run_tick(1'b0, 1'b0, "c_per0");
        end
        stop("c_stop");

        // Reset at cnt=2 aborts at once; restart on first edge after release.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 16'd2, 1'b0, 1'b0, 1'b1, "e_start");
        run_tick(1'b1, 1'b0, "e_c1");
        run_tick(1'b1, 1'b0, "e_c2");
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0, "e_rst");
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 16'd2, 1'b0, 1'b0, 1'b1, "e_restart");
        run_tick(1'b1, 1'b0, "e_r1");
        run_tick(1'b1, 1'b0, "e_r2");
        run_tick(1'b0, 1'b0, "e_r3");
        run_tick(1'b0, 1'b1, "e_rwrap");
        stop("e_stop");

        // period=8 duty=4, then reload period=3 duty=1 mid-period.
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd8, 16'd4, 1'b0, 1'b0, 1'b1, "d_start");
`ifdef PWM_TICK_GEN_SHADOW_EN
        run_tick(1'b1, 1'b0, "s_c1");
        run_tick(1'b1, 1'b0, "s_c2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'd3, 16'd1, 1'b1, 1'b0, 1'b1, "s_load_c2");
        run_tick(1'b1, 1'b0, "s_c4");
        run_tick(1'b0, 1'b0, "s_c5");
        run_tick(1'b0, 1'b0, "s_c6");
        run_tick(1'b0, 1'b0, "s_c7");
        run_tick(1'b0, 1'b1, "s_wrap8");
        run_tick(1'b1, 1'b0, "s_p3_c1");
        run_tick(1'b0, 1'b0, "s_p3_c2");
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'd5, 16'd5, 1'b0, 1'b1, 1'b1, "s_load_wrap");
        run_tick(1'b1, 1'b0, "s_old_c1");
        run_tick(1'b0, 1'b0, "s_old_c2");
        run_tick(1'b0, 1'b1, "s_old_wrap");
        run_tick(1'b1, 1'b0, "s_p5_c1");
        run_tick(1'b1, 1'b0, "s_p5_c2");
        run_tick(1'b1, 1'b0, "s_p5_c3");
        run_tick(1'b1, 1'b0, "s_p5_c4");
        run_tick(1'b1, 1'b1, "s_p5_wrap");
        run_tick(1'b1, 1'b0, "s_p5_c1b");
`else
        run_tick(1'b1, 1'b0, "n_c1");
        run_tick(1'b1, 1'b0, "n_c2");
        run_tick(1'b1, 1'b0, "n_c3");
        run_tick(1'b1, 1'b0, "n_c4");
        run_tick(1'b0, 1'b0, "n_c5");
        run_tick(1'b0, 1'b0, "n_c6");
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'd3, 16'd1, 1'b0, 1'b0, 1'b1, "n_load_c6");
        run_tick(1'b0, 1'b1, "n_shrink_wrap");
        run_tick(1'b1, 1'b0, "n_p3_c1");
        run_tick(1'b0, 1'b0, "n_p3_c2");
        run_tick(1'b0, 1'b1, "n_p3_wrap");
        run_tick(1'b1, 1'b0, "n_p3_c1b");
`endif
        stop("d_stop");

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk_in);
            guard++;
        end
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
